// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: SR, Cause, EPC, PRId, exception/interrupt entry and eret forwarding.
module cp0_regs #(
   parameter logic [31:0] PRID     = 32'h2022_1106,
   parameter int unsigned HW_INT_W = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [4:0]          cp0_addr,
   input  logic [31:0]         cp0_in,
   output logic [31:0]         cp0_out,
   input  logic [31:0]         vpc,
   input  logic                bd_in,
   input  logic [4:0]          exc_code_in,
   input  logic [HW_INT_W-1:0] hw_int,
   input  logic                exl_clr,
   output logic                req,
   output logic [31:0]         EPC_out
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   logic [HW_INT_W-1:0] im_q, im_d;
   logic                exl_q, exl_d;
   logic                ie_q, ie_d;
   logic                bd_q, bd_d;
   logic [HW_INT_W-1:0] ip_q, ip_d;
   logic [4:0]          exc_code_q, exc_code_d;
   logic [31:0]         epc_q, epc_d;

   logic        int_req;
   logic        exc_req;
   logic        wr_sr;
   logic        wr_epc;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   // Entry decision uses the live interrupt lines; EXL blocks any nested entry.
   always_comb begin
      int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
      exc_req = (exc_code_in != 5'd0) & ~exl_q;
      req     = int_req | exc_req;
      wr_sr   = en & ~req & (cp0_addr == ADDR_SR);
      wr_epc  = en & ~req & (cp0_addr == ADDR_EPC);
   end

   // Next-state: entry beats eret, eret beats the mtc0 EXL bit.
   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_d       = hw_int;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      if (req) begin
         exl_d      = 1'b1;
         bd_d       = bd_in;
         exc_code_d = int_req ? 5'd0 : exc_code_in;
         epc_d      = bd_in ? (vpc - 32'd4) : vpc;
      end else begin
         if (wr_sr) begin
            im_d  = cp0_in[15:10];
            ie_d  = cp0_in[0];
            exl_d = cp0_in[1];
         end
         if (wr_epc) begin
            epc_d = cp0_in;
         end
         if (exl_clr) begin
            exl_d = 1'b0;
         end
      end
   end

   // Register state with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_q       <= '0;
         exc_code_q <= 5'd0;
         epc_q      <= 32'd0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_q       <= ip_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

   // Read mux and EPC forwarding so mtc0 EPC followed by eret returns to the new address.
   always_comb begin
      sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
      cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
      case (cp0_addr)
         ADDR_SR:    cp0_out = sr_val;
         ADDR_CAUSE: cp0_out = cause_val;
         ADDR_EPC:   cp0_out = epc_q;
         ADDR_PRID:  cp0_out = PRID;
         default:    cp0_out = 32'd0;
      endcase
      EPC_out = wr_epc ? cp0_in : epc_q;
   end

endmodule
